// File: rtl/dcache_pkg.sv
// Shared geometry, address-field positions and FSM encoding for the direct-mapped data cache.
// No logic; constants and helpers only.
// Not applicable: no flow control.
package dcache_pkg;

    localparam int DC_NUM_SETS  = 16;
    localparam int DC_LINE_BITS = 256;
    localparam int ADDR_BITS    = 32;
    localparam int WORD_BITS    = 32;
    localparam int WORD_LSB     = 2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_ALLOCATE  = 2'd2;
    localparam logic [1:0] ST_REFILL    = 2'd3;

    // Byte-offset width of a line; the index field starts here.
    function automatic int offset_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int tag_bits(input int num_sets, input int line_bits);
        return ADDR_BITS - offset_bits(line_bits) - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag and line storage: one shared index, async read, line-wide or word-wide write.
// Latency: read combinational, write at the next rising edge.
// Backpressure: none; writes always accepted.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_SETS  = DC_NUM_SETS,
    parameter int LINE_BITS = DC_LINE_BITS,
    parameter int TAG_BITS  = tag_bits(DC_NUM_SETS, DC_LINE_BITS)
) (
    input  logic                                   clk,
    input  logic [$clog2(NUM_SETS)-1:0]            idx,
    input  logic                                   line_we,
    input  logic [TAG_BITS-1:0]                    tag_wr,
    input  logic [LINE_BITS-1:0]                   line_wr,
    input  logic                                   word_we,
    input  logic [$clog2(LINE_BITS/WORD_BITS)-1:0] word_sel,
    input  logic [WORD_BITS-1:0]                   word_wr,
    output logic [TAG_BITS-1:0]                    tag_rd,
    output logic [LINE_BITS-1:0]                   line_rd
);

    logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS];
    logic [LINE_BITS-1:0] data_mem [NUM_SETS];

    // A refill replaces the whole line, so it takes priority over a word store.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[idx]  <= tag_wr;
            data_mem[idx] <= line_wr;
        end else if (word_we) begin
            data_mem[idx][word_sel*WORD_BITS +: WORD_BITS] <= word_wr;
        end
    end

    assign tag_rd  = tag_mem[idx];
    assign line_rd = data_mem[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller between the MEM stage and line memory.
// Latency: hits complete in the request cycle; clean miss L+2 stall cycles, dirty miss 2L+2.
// Backpressure: cpu_stall_o freezes the pipeline; mem_req_o is held until the mem_ack_i pulse.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS  = DC_NUM_SETS,
    parameter int LINE_BITS = DC_LINE_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int OFF_BITS  = offset_bits(LINE_BITS);
    localparam int IDX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS  = tag_bits(NUM_SETS, LINE_BITS);
    localparam int WSEL_BITS = OFF_BITS - WORD_LSB;

    logic [1:0]           state, state_nxt;
    logic [NUM_SETS-1:0]  valid_q, dirty_q;

    logic [IDX_BITS-1:0]  cpu_idx;
    logic [TAG_BITS-1:0]  cpu_tag;
    logic [WSEL_BITS-1:0] word_sel;
    logic [TAG_BITS-1:0]  tag_rd;
    logic [LINE_BITS-1:0] line_rd;
    logic                 in_idle, hit, miss, store_hit, fill;
    logic                 unused_byte_bits;

    assign cpu_idx          = cpu_addr_i[OFF_BITS +: IDX_BITS];
    assign cpu_tag          = cpu_addr_i[ADDR_BITS-1 -: TAG_BITS];
    assign word_sel         = cpu_addr_i[WORD_LSB +: WSEL_BITS];
    assign unused_byte_bits = ^cpu_addr_i[WORD_LSB-1:0];

    assign in_idle   = (state == ST_IDLE);
    assign hit       = cpu_req_i & valid_q[cpu_idx] & (tag_rd == cpu_tag);
    assign miss      = in_idle & cpu_req_i & ~hit;
    assign store_hit = in_idle & hit & cpu_we_i & ~rst_i;
    // Reset wins over a coincident ack so an aborted fetch never lands in the array.
    assign fill      = (state == ST_ALLOCATE) & mem_ack_i & ~rst_i;

    // The pipeline holds the address stable across a miss, so one index serves every access.
    dcache_sram #(
        .NUM_SETS  (NUM_SETS),
        .LINE_BITS (LINE_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_sram (
        .clk      (clk_i),
        .idx      (cpu_idx),
        .line_we  (fill),
        .tag_wr   (cpu_tag),
        .line_wr  (mem_data_i),
        .word_we  (store_hit),
        .word_sel (word_sel),
        .word_wr  (cpu_data_i),
        .tag_rd   (tag_rd),
        .line_rd  (line_rd)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (miss) begin
                    state_nxt = (valid_q[cpu_idx] & dirty_q[cpu_idx]) ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: if (mem_ack_i) state_nxt = ST_ALLOCATE;
            ST_ALLOCATE:  if (mem_ack_i) state_nxt = ST_REFILL;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state <= state_nxt;
            if (fill) begin
                valid_q[cpu_idx] <= 1'b1;
                dirty_q[cpu_idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[cpu_idx] <= 1'b1;
            end
        end
    end

    always_comb begin
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        if (!rst_i) begin
            cpu_stall_o = miss | ~in_idle;
            case (state)
                ST_WRITEBACK: begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_addr_o = {tag_rd, cpu_idx, {OFF_BITS{1'b0}}};
                end
                ST_ALLOCATE: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = {cpu_tag, cpu_idx, {OFF_BITS{1'b0}}};
                end
                default: ;
            endcase
        end
    end

    assign mem_data_o = line_rd;
    assign cpu_data_o = line_rd[word_sel*WORD_BITS +: WORD_BITS];

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16, giving the number of direct-mapped sets (power of two).
REQ-002 SHALL have parameter LINE_BITS, default 256, giving the cache line width in bits (32-byte line).
REQ-003 SHALL have the ports below; one clock; reset is synchronous and active-high (clk_i, rst_i).
REQ-004 clk_i  in  1  clock, rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 cpu_req_i  in  1  pipeline access request (MemRead_o | MemWrite_o from MEM stage).
REQ-007 cpu_we_i  in  1  1=store (sw), 0=load (lw).
REQ-008 cpu_addr_i  in  32  byte address; [1:0] ignored, [4:2] word select, [8:5] index, [31:9] tag.
REQ-009 cpu_data_i  in  32  store data.
REQ-010 cpu_data_o  out  32  load data, valid when cpu_req_i=1, cpu_we_i=0, cpu_stall_o=0.
REQ-011 cpu_stall_o  out  1  freezes the pipeline while an access cannot complete this cycle.
REQ-012 mem_req_o  out  1  memory request, held until mem_ack_i.
REQ-013 mem_we_o  out  1  1=line writeback, 0=line fetch.
REQ-014 mem_addr_o  out  32  line-aligned address ([4:0]=0).
REQ-015 mem_data_o  out  LINE_BITS  victim line for writeback.
REQ-016 mem_data_i  in  LINE_BITS  fetched line, valid with mem_ack_i.
REQ-017 mem_ack_i  in  1  one-cycle completion pulse; arbitrary latency of at least 1 cycle after mem_req_o rises.

Function
REQ-018 Per set SHALL store valid, dirty, 23-bit tag and LINE_BITS data; write-back, write-allocate policy.
REQ-019 Hit SHALL be cpu_req_i & valid[index] & (tag[index]==addr tag), evaluated combinationally in IDLE.
REQ-020 Hit load: cpu_stall_o=0 in the same cycle; cpu_data_o = word [4:2] of the line.
REQ-021 Hit store: cpu_stall_o=0 in the same cycle; word written and dirty set at the next rising edge.
REQ-022 No request: cpu_stall_o=0; no state change.
REQ-023 FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
REQ-024 IDLE, miss, victim valid & dirty -> WRITEBACK; miss otherwise -> ALLOCATE; cpu_stall_o=1 in the miss cycle.
REQ-025 WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag,index,5'b0}, mem_data_o=victim line; mem_ack_i -> ALLOCATE.
REQ-026 ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag,index,5'b0}; mem_ack_i -> REFILL, capturing mem_data_i into the line, tag written, valid=1, dirty=0.
REQ-027 REFILL: one cycle, cpu_stall_o=1, mem_req_o=0; -> IDLE, where the access re-evaluates as a hit.
REQ-028 cpu_stall_o SHALL be 1 in every cycle spent in WRITEBACK, ALLOCATE and REFILL.
REQ-029 mem_req_o SHALL deassert in the cycle after mem_ack_i is sampled; mem_ack_i outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-030 Address and data inputs SHALL be held stable by the stalled pipeline during a miss; the controller does not latch them.
REQ-031 Miss latency with memory latency L: clean miss = L+2 stall cycles; dirty miss = 2L+2.

Reset
REQ-032 rst_i SHALL clear all valid and dirty bits, force state IDLE, and drive mem_req_o=0, mem_we_o=0, cpu_stall_o=0 (no request), mem_addr_o=0.
REQ-033 rst_i mid-WRITEBACK/ALLOCATE SHALL abort the transfer with no array update; a later mem_ack_i SHALL be ignored.
REQ-034 Tag/data arrays need no reset; content is unobservable while valid=0.

Structure
REQ-035 Shared package SHALL hold NUM_SETS, LINE_BITS, address field positions and the FSM state encoding.
REQ-036 Tag/data storage SHALL be sub-module dcache_sram (one read/write port, write enable, line-wide and word-wide write).

Verification
REQ-037 Cold load 0x0000_0040 after reset, L=3 -> ALLOCATE addr 0x40, 5 stall cycles, then cpu_data_o = word 0 of fetched line.
REQ-038 Load hit 0x44 afterwards -> cpu_stall_o=0 same cycle, data = word 1.
REQ-039 Store 0xDEADBEEF to 0x48 (hit) -> no stall, dirty[2]=1; load 0x48 returns 0xDEADBEEF.
REQ-040 Load 0x248 (same index 2, new tag), L=3 -> WRITEBACK addr 0x40 with stored word, then ALLOCATE addr 0x240, 8 stall cycles.
REQ-041 rst_i asserted in ALLOCATE, late mem_ack_i -> state IDLE, mem_req_o=0, all lines invalid, ack ignored.
REQ-042 L=1 and L=20 for the REQ-037 access -> stall counts 3 and 22.
